// File: rtl/pe64_grant_decoder.sv
// Index-to-one-hot grant decoder for the pe64 encoder: owns the pending-request
// register, expands the 6-bit winner index through a 16x4 row/column split.
module pe64_grant_decoder #(
  parameter bit CLR_ON_GRANT = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      set_mask,
  input  logic             clr_all,
  output logic [63:0]      pending,
  input  logic             in_valid,
  input  logic [5:0]       in_idx,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_onehot,
  output logic [5:0]       out_idx,
  output logic             out_miss,
  output logic [CNT_W-1:0] grant_cnt
);

  logic [63:0]      pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [63:0]      onehot_q, onehot_d;
  logic [5:0]       idx_q, idx_d;
  logic             miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] row_oh;
  logic [3:0]  col_oh;
  logic [63:0] onehot;
  logic [63:0] grant_clr;
  logic        acc;

  always_comb begin
    row_oh = 16'b0;
    col_oh = 4'b0;
    row_oh[in_idx[5:2]] = 1'b1;
    col_oh[in_idx[1:0]] = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 4; c++) begin
        onehot[4*r+c] = row_oh[r] & col_oh[c];
      end
    end
  end

  assign in_ready = ~valid_q | out_ready;
  assign acc      = in_valid & in_ready;

  // Set is OR-ed in after the clear so a request re-armed in the grant cycle survives.
  assign grant_clr = (acc && CLR_ON_GRANT) ? onehot : 64'b0;

  always_comb begin
    pending_d = clr_all ? set_mask : ((pending_q & ~grant_clr) | set_mask);
    valid_d   = valid_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    miss_d    = miss_q;
    cnt_d     = cnt_q;
    if (acc) begin
      valid_d  = 1'b1;
      onehot_d = onehot;
      idx_d    = in_idx;
      miss_d   = ~pending_q[in_idx];
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 64'b0;
      valid_q   <= 1'b0;
      onehot_q  <= 64'b0;
      idx_q     <= 6'b0;
      miss_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending    = pending_q;
  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;
  assign out_idx    = idx_q;
  assign out_miss   = miss_q;
  assign grant_cnt  = cnt_q;

endmodule

// File: tb/tb_pe64_grant_decoder.sv
// Randomized scoreboard bench for pe64_grant_decoder: a driver updates a
// behavioural model and queues expected grants; a monitor checks them on handoff.
module tb_pe64_grant_decoder;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      set_mask;
  logic             clr_all;
  logic [63:0]      pending;
  logic             in_valid;
  logic [5:0]       in_idx;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_onehot;
  logic [5:0]       out_idx;
  logic             out_miss;
  logic [CNT_W-1:0] grant_cnt;

  pe64_grant_decoder #(.CLR_ON_GRANT(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .set_mask(set_mask), .clr_all(clr_all), .pending(pending),
    .in_valid(in_valid), .in_idx(in_idx), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_idx(out_idx), .out_miss(out_miss), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] onehot;
    logic [5:0]  idx;
    logic        miss;
  } grant_t;

  grant_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [63:0] m_pend;
  logic        m_ov;
  int          m_cnt;
  grant_t      m_last;
  int          cnt_max;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected grant per output handoff
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got grant idx %0d expected none", out_idx);
      end else begin
        grant_t e;
        e = exp_q.pop_front();
        check("sb_onehot", out_onehot, e.onehot);
        check("sb_idx", {58'b0, out_idx}, {58'b0, e.idx});
        check("sb_miss", {63'b0, out_miss}, {63'b0, e.miss});
      end
    end
  end

  function automatic int lowest(input logic [63:0] p);
    for (int i = 0; i < 64; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_pending"}, pending, m_pend);
    check({tag, "_out_valid"}, {63'b0, out_valid}, {63'b0, m_ov});
    check({tag, "_grant_cnt"}, {{(64-CNT_W){1'b0}}, grant_cnt}, 64'(m_cnt));
    check({tag, "_onehot_hold"}, out_onehot, m_last.onehot);
    check({tag, "_idx_hold"}, {58'b0, out_idx}, {58'b0, m_last.idx});
    check({tag, "_miss_hold"}, {63'b0, out_miss}, {63'b0, m_last.miss});
  endtask

  // One clock: drive inputs, check handshake, advance the model, check state.
  task automatic step(input logic v, input logic [5:0] idx, input logic [63:0] sm,
                      input logic ca, input logic ordy, input string tag);
    logic acc;
    logic rdy_exp;
    in_valid  = v;
    in_idx    = idx;
    set_mask  = sm;
    clr_all   = ca;
    out_ready = ordy;
    #1;
    rdy_exp = !m_ov || ordy;
    check({tag, "_in_ready"}, {63'b0, in_ready}, {63'b0, rdy_exp});
    acc = v && rdy_exp;
    if (acc) begin
      m_last.onehot = 64'b1 << idx;
      m_last.idx    = idx;
      m_last.miss   = !m_pend[idx];
      exp_q.push_back(m_last);
      if (m_cnt < cnt_max) m_cnt++;
    end
    if (ca) m_pend = sm;
    else    m_pend = (m_pend & ~(acc ? (64'b1 << idx) : 64'b0)) | sm;
    if (acc)       m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input logic [63:0] sm);
    rst = 1'b1;
    set_mask = sm;
    in_valid = 1'b1;
    in_idx = 6'd3;
    clr_all = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pend = 64'b0;
    m_ov = 1'b0;
    m_cnt = 0;
    m_last = '0;
    exp_q.delete();
    in_valid = 1'b0;
    set_mask = 64'b0;
    check_state("reset");
  endtask

  initial begin
    int e;
    cnt_max = (1 << CNT_W) - 1;
    rst = 1'b1;
    set_mask = 64'b0; clr_all = 1'b0; in_valid = 1'b0; in_idx = 6'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b1;
    #1;
    check("reset_in_ready", {63'b0, in_ready}, 64'b1);

    // Two requests drained by a lowest-first encoder in the loop
    step(1'b0, 6'd0, 64'h8000_0000_0000_0001, 1'b0, 1'b1, "enc_arm");
    for (int i = 0; i < 3; i++) begin
      e = lowest(m_pend);
      step(e >= 0, (e >= 0) ? 6'(e) : 6'd0, 64'b0, 1'b0, 1'b1, "enc_loop");
    end
    check("enc_cnt2", 64'(grant_cnt), 64'd2);
    check("enc_pend0", pending, 64'b0);

    // Direct sweep over every index with all bits pending
    step(1'b0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sweep_arm");
    for (int i = 0; i < 64; i++) step(1'b1, 6'(i), 64'b0, 1'b0, 1'b1, "sweep");
    step(1'b0, 6'd0, 64'b0, 1'b0, 1'b1, "sweep_end");

    // Miss on an empty pending register
    step(1'b1, 6'd37, 64'b0, 1'b0, 1'b1, "miss37");
    check("miss37_flag", {63'b0, out_miss}, 64'b1);
    step(1'b0, 6'd0, 64'b0, 1'b0, 1'b1, "miss_drain");

    // Back-pressure holds the grant and blocks further accepts
    step(1'b0, 6'd0, 64'h20, 1'b0, 1'b1, "bp_arm");
    step(1'b1, 6'd5, 64'b0, 1'b0, 1'b0, "bp_acc");
    for (int i = 0; i < 3; i++) step(1'b1, 6'd5, 64'b0, 1'b0, 1'b0, "bp_hold");
    check("bp_onehot", out_onehot, 64'h20);
    step(1'b0, 6'd0, 64'b0, 1'b0, 1'b1, "bp_release");

    // Re-armed request in the grant cycle survives the clear
    step(1'b0, 6'd0, 64'h400, 1'b0, 1'b1, "rearm_arm");
    step(1'b1, 6'd10, 64'h400, 1'b0, 1'b1, "rearm_acc");
    check("rearm_bit10", {63'b0, pending[10]}, 64'b1);
    step(1'b1, 6'd10, 64'b0, 1'b0, 1'b1, "rearm_again");
    step(1'b0, 6'd0, 64'b0, 1'b0, 1'b1, "rearm_end");

    // Randomized traffic, long enough to saturate the counter
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] sm;
      logic [5:0]  idx;
      sm = 64'b0;
      if ($urandom_range(0, 3) == 0) sm[$urandom_range(0, 63)] = 1'b1;
      if ($urandom_range(0, 15) == 0) sm = {$urandom, $urandom};
      e = lowest(m_pend);
      idx = ($urandom_range(0, 1) == 0 && e >= 0) ? 6'(e) : 6'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, idx, sm, $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0, "rand");
    end
    check("cnt_saturated", 64'(grant_cnt), 64'(cnt_max));
    step(1'b0, 6'd0, 64'b0, 1'b0, 1'b1, "rand_drain");
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset with a held grant and pending=FF
    step(1'b0, 6'd0, 64'hFF, 1'b1, 1'b1, "rst_arm");
    step(1'b1, 6'd2, 64'b0, 1'b0, 1'b0, "rst_hold");
    check("rst_pre_valid", {63'b0, out_valid}, 64'b1);
    step(1'b0, 6'd0, 64'hFD, 1'b0, 1'b0, "rst_pre");
    do_reset(64'hFF);
    check("rst_valid0", {63'b0, out_valid}, 64'b0);
    check("rst_pend0", pending, 64'b0);
    check("rst_cnt0", 64'(grant_cnt), 64'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe64_grant_decoder.md
# pe64_grant_decoder

Sequential index-to-one-hot decoder that sits on the output side of the 64-bit priority encoder (pe64_lookahead/pe64_standard). It owns the 64-bit pending-request register, accepts the encoder's 6-bit winner index over a valid/ready handshake, and expands it back through the same 16-row x 4-column 2D split into a registered one-hot grant. It then clears the granted bit from pending so the encoder sees the next request on the following pass. It also keeps a saturating grant counter and a miss flag for debug.

## Interface
- CLR_ON_GRANT, 1, 1: accepted index clears its pending bit; 0: pending is only modified by set_mask and clr_all
- CNT_W, 16, width of grant counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- set_mask  in  64  request bits OR-ed into pending every cycle
- clr_all  in  1  clears pending next cycle; set_mask in the same cycle still applies
- pending  out  64  pending register, fed combinationally to the external pe64 d input
- in_valid  in  1  index valid, normally the pe64 v output
- in_idx  in  6  winner index, normally the pe64 q output
- in_ready  out  1  block can accept an index this cycle
- out_valid  out  1  grant register holds a valid grant
- out_ready  in  1  consumer takes the grant
- out_onehot  out  64  one-hot grant, bit in_idx set
- out_idx  out  6  registered copy of accepted index
- out_miss  out  1  accepted index addressed a bit that was not pending at accept
- grant_cnt  out  CNT_W  count of accepted indices, saturating at all-ones

## Operation
- Decode: row = in_idx[5:2] gives a 16-bit one-hot row_oh; col = in_idx[1:0] gives a 4-bit one-hot col_oh.
  - onehot[4*r+c] = row_oh[r] & col_oh[c].
  - This is the exact inverse of the encoder's {row_index, col_index} packing.
- Accept: acc = in_valid & in_ready.
- in_ready = ~out_valid | out_ready. One-deep output register; no combinational path from in_valid to out_valid.
- On acc:
  - out_onehot <= onehot, out_idx <= in_idx, out_valid <= 1.
  - out_miss <= ~pending[in_idx].
  - grant_cnt <= grant_cnt + 1, unless already all-ones.
- On out_ready & out_valid & ~acc: out_valid <= 0. out_onehot, out_idx and out_miss hold their last values.
- Pending update, evaluated in priority order:
  - clr_all: pending <= set_mask.
  - else: pending <= (pending & ~(acc & CLR_ON_GRANT ? onehot : 0)) | set_mask.
  - Set wins over the grant clear on the same bit in the same cycle, so a re-armed request is not lost.
- An index for a non-pending bit is still decoded and granted, with out_miss=1. Pending is unchanged in that case, since clearing a 0 bit has no effect.
- in_valid while in_ready=0: index not consumed and pending not cleared. The upstream encoder re-evaluates next cycle, which is legal because the index is a function of pending.

## Timing
- Reset values: pending=0, out_valid=0, out_onehot=0, out_idx=0, out_miss=0, grant_cnt=0. in_ready=1 in the first cycle after reset.
- Latency:
  - Accept cycle N gives out_valid/out_onehot at N+1.
  - Pending clear is visible at N+1, so the encoder index at N+1 already excludes the grant.
- Throughput: one grant per cycle with out_ready held high.
- Back-pressure: while out_valid=1 and out_ready=0, the outputs are stable and in_ready=0.
- rst mid-transfer drops the held grant (out_valid=0 next cycle) and clears pending, ignoring set_mask in that cycle.
- grant_cnt wraps never; it holds at 2^CNT_W-1.

## Test plan
- Reset, then set_mask=64'h8000_0000_0000_0001 for one cycle, out_ready=1, encoder model in loop:
  - grants idx 0 then idx 63; out_onehot = 64'h1, then 64'h8000_0000_0000_0000.
  - pending=0 after 2 accepts; grant_cnt=2.
- Sweep in_idx 0..63 directly with pending all-ones:
  - out_onehot == 1<<idx each cycle; out_miss=0; pending ends at 0.
- in_idx=6'd37 with pending=0 -> out_onehot bit 37 set, out_miss=1, pending stays 0.
- out_ready=0 for 3 cycles after a grant of idx 5:
  - out_valid=1, out_onehot=64'h20 held; in_ready=0; pending bit 5 cleared only once.
- Accept idx 10 while set_mask=64'h400 in the same cycle -> pending[10]=1 afterwards (set wins), and a second grant of idx 10 follows.
- Assert rst while out_valid=1 and pending=64'hFF -> next cycle out_valid=0, pending=0, grant_cnt=0.
